// File: rtl/beat_sequencer.sv
// beat_sequencer: timing-beat generator and instruction sequencer with run/halt/step control.
//   in : clk, rst (sync, active-high), start, step_mode, step, ir_op[OPW-1:0]
//   out: T0..T7 one-hot beats, LD/ADD/SUB/AND/OR/SHL/XOR/HALT one-hot opcode flags,
//        running, halted, illegal (sticky), instr_count[ICW-1:0] (saturating)
module beat_sequencer #(
    parameter int OPW = 4,
    parameter int ICW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           step_mode,
    input  logic           step,
    input  logic [OPW-1:0] ir_op,
    output logic           T0,
    output logic           T1,
    output logic           T2,
    output logic           T3,
    output logic           T4,
    output logic           T5,
    output logic           T6,
    output logic           T7,
    output logic           LD,
    output logic           ADD,
    output logic           SUB,
    output logic           AND,
    output logic           OR,
    output logic           SHL,
    output logic           XOR,
    output logic           HALT,
    output logic           running,
    output logic           halted,
    output logic           illegal,
    output logic [ICW-1:0] instr_count
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALTED} state_t;
    state_t         state_q, state_d;
    logic [2:0]     beat_q, beat_d;
    logic [7:0]     t_q, t_d, op_q, op_d;
    logic           ill_q, ill_d;
    logic [ICW-1:0] cnt_q, cnt_d, cnt_inc;
    logic           hi_zero, is_halt, is_legal;
    always_comb begin
        hi_zero  = (ir_op >> 4) == '0;
        is_halt  = hi_zero && ir_op[3:0] == 4'hF;
        is_legal = hi_zero && !ir_op[3] && ir_op[2:0] != 3'd0;
        cnt_inc  = cnt_q + ICW'(cnt_q != '1);
        state_d  = state_q;
        beat_d   = beat_q;
        op_d     = op_q;
        ill_d    = ill_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = start ? RUN : IDLE;
                beat_d  = 3'd0;
            end
            PAUSE: begin
                state_d = step ? RUN : PAUSE;
                beat_d  = 3'd0;
            end
            HALTED: begin
                // HALT flag is a single-cycle pulse on entry
                op_d    = '0;
                state_d = start ? RUN : HALTED;
                ill_d   = start ? 1'b0 : ill_q;
                beat_d  = 3'd0;
            end
            RUN: begin
                if (beat_q == 3'd2 && is_halt) begin
                    state_d = HALTED;
                    op_d    = 8'h80;
                    cnt_d   = cnt_inc;
                end else if (beat_q == 3'd2 && is_legal) begin
                    beat_d = 3'd3;
                    op_d   = 8'(1) << (ir_op[2:0] - 3'd1);
                end else if (beat_q == 3'd2 || beat_q == 3'd7) begin
                    // instruction boundary: end of T7, or end of T2 for an illegal opcode
                    beat_d  = 3'd0;
                    op_d    = '0;
                    state_d = step_mode ? PAUSE : RUN;
                    ill_d   = ill_q | (beat_q == 3'd2);
                    cnt_d   = beat_q == 3'd7 ? cnt_inc : cnt_q;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        t_d = state_d == RUN ? 8'(1) << beat_d : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            t_q     <= '0;
            op_q    <= '0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            t_q     <= t_d;
            op_q    <= op_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end
    assign {T7, T6, T5, T4, T3, T2, T1, T0}            = t_q;
    assign {HALT, XOR, SHL, OR, AND, SUB, ADD, LD}     = op_q;
    assign running     = state_q == RUN;
    assign halted      = state_q == HALTED;
    assign illegal     = ill_q;
    assign instr_count = cnt_q;
endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Timing-beat generator and instruction sequencer for the model computer. Produces the one-hot beat pulses T0..T7 and the registered one-hot opcode flags (LD, ADD, SUB, AND, OR, SHL, XOR, HALT) consumed by the combinational control-signal decoder. Provides run/halt control, single-step mode, illegal-opcode detection and a retired-instruction counter. Sits between the front-panel/testbench controls and the control decoder, and samples the opcode field of IR.

## Interface
- OPW, 4, opcode field width; must be ≥ 4.
- ICW, 16, retired-instruction counter width.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; leaves IDLE or HALTED and begins fetch.
- step_mode  in  1  1 = pause after every completed instruction.
- step  in  1  single-cycle pulse; resumes from PAUSE for one instruction.
- ir_op  in  OPW  opcode field of IR; valid during the T2 beat.
- T0..T7  out  1 each  one-hot beat pulses, registered; all 0 outside RUN.
- LD, ADD, SUB, AND, OR, SHL, XOR, HALT  out  1 each  registered one-hot opcode flags.
- running  out  1  1 while in RUN.
- halted  out  1  1 while in HALTED.
- illegal  out  1  sticky; set on an undefined opcode, cleared by rst or start.
- instr_count  out  ICW  retired-instruction count, saturating.

## Operation
- States: IDLE, RUN, PAUSE, HALTED. Beat counter b ∈ 0..7 drives one-hot T outputs only in RUN.
- Opcode map: 1 LD, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 SHL, 7 XOR, 15 HALT. All other values are illegal. Upper bits above bit 3 must be 0 for a legal decode.
- Fetch beats T0–T2 are common to all instructions. ir_op is sampled on the clock edge that ends T2.
- Legal non-HALT opcode: the matching flag is asserted for beats T3..T7 and is 0 during T0..T2. After T7, instr_count increments and the counter wraps to T0, or goes to PAUSE if step_mode = 1.
- HALT opcode: on the edge ending T2, go to HALTED. All T outputs go to 0. HALT pulses high for exactly one cycle, the first HALTED cycle, then stays 0. Increment instr_count. halted = 1.
- Illegal opcode: on the edge ending T2, set illegal and treat the instruction as a NOP. The next beat is T0, or PAUSE if step_mode = 1. No flag is asserted and instr_count does not increment.
- IDLE → RUN on start. HALTED → RUN on start; this clears halted and illegal. instr_count is preserved.
- PAUSE → RUN on step, beginning at T0.
- step_mode is sampled only at instruction boundaries (end of T7, or end of T2 for an illegal opcode). Changes mid-instruction take effect at the next boundary.
- start in RUN or PAUSE: ignored. step outside PAUSE: ignored. start and step together in PAUSE: treated as step.
- instr_count saturates at 2^ICW−1. It is cleared only by rst.

## Timing
- Reset values: state IDLE, all T and opcode flags 0, running 0, halted 0, illegal 0, instr_count 0.
- rst has priority over every other input. Asserting rst mid-instruction forces IDLE on the next edge, with outputs as above.
- start sampled at edge k → T0 = 1 in cycle k+1.
- One beat per clock in RUN. A legal instruction takes 8 cycles from T0 to T7. An illegal instruction takes 3 cycles (T0–T2).
- Back-to-back instructions: T7 in cycle n → T0 in cycle n+1. There are no idle cycles.
- step_mode = 1: T7 in cycle n → PAUSE in cycle n+1. A step sampled at edge m → T0 in cycle m+1.
- Opcode flags change only at the T2→T3 edge (set) and the T7→next edge (clear).
- instr_count updates on the same edge that leaves T7, or the edge that enters HALTED.
- Exactly one T output is high in every RUN cycle. In all other states every T output is 0.

## Test plan
- Reset, then start, with ir_op = 2 at T2 → T0..T7 in 8 consecutive cycles; ADD high only during T3–T7; instr_count = 1; next cycle T0.
- Program sequence LD, XOR, HALT → each flag is one-hot during its T3–T7 window; HALTED entered the cycle after the third T2; HALT high 1 cycle; halted = 1; instr_count = 3; T all 0.
- ir_op = 9 at T2 → illegal = 1; T0 follows immediately; instr_count unchanged; the next legal instruction executes normally with illegal still 1.
- step_mode = 1 with opcode 5 → PAUSE after T7; T stays all 0 for 10 cycles; step → T0 next cycle; a start pulse in PAUSE has no effect.
- rst asserted during T4 of SUB → next cycle IDLE with all outputs 0; start → T0 with instr_count = 0.
- ICW = 2, five legal instructions → instr_count sticks at 3; HALTED then start → RUN; count stays 3; illegal cleared.
